// File: rtl/io_fifo_arb_pkg.sv
// Shared definitions for the io FIFO read-side arbiter: state encoding,
// client indices and the round-robin pick helper.
package io_fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int unsigned N_CLIENTS = 2;

  localparam logic CLIENT_ACSI = 1'b0;
  localparam logic CLIENT_FDC  = 1'b1;

  function automatic logic [N_CLIENTS-1:0] client_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // With both clients requesting, the one not served last wins.
  function automatic logic rr_pick(input logic [N_CLIENTS-1:0] req_in,
                                   input logic last_in);
    logic pick;
    if (req_in == 2'b11) begin
      pick = ~last_in;
    end else begin
      pick = req_in[1];
    end
    return pick;
  endfunction

endpackage

// File: rtl/io_fifo_arbiter.sv
// Shares the io-controller-to-ST byte FIFO between the ACSI and floppy DMA
// engines: round-robin grant, exact-length pop, registered valid/ready output.
//
// state | meaning
// IDLE  | no client granted; sample req and pick a winner
// GRANT | load remaining byte count from the winner's len
// XFER  | pop bytes into the output register until count exhausted or abort
// DONE  | one-cycle done pulse, record last served client, drop grant
module io_fifo_arbiter
  import io_fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req,
  input  logic [LEN_WIDTH-1:0]  len0,
  input  logic [LEN_WIDTH-1:0]  len1,
  input  logic [1:0]            abort,
  input  logic                  fifo_data_available,
  input  logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            dout_valid,
  input  logic [1:0]            dout_ready,
  output logic [1:0]            grant,
  output logic [1:0]            done,
  output logic                  busy
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  arb_state_t            r_state;
  logic [1:0]            r_grant;
  logic                  r_last;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_valid;

  arb_state_t            w_state_nxt;
  logic [1:0]            w_grant_nxt;
  logic                  w_last_nxt;
  logic [LEN_WIDTH-1:0]  w_remaining_nxt;
  logic [DATA_WIDTH-1:0] w_dout_nxt;
  logic                  w_valid_nxt;
  logic                  w_pop;

  logic                  w_gidx;
  logic                  w_ready;
  logic                  w_abort;
  logic [LEN_WIDTH-1:0]  w_len_sel;
  logic                  w_can_load;

  // Grant is one-hot, so bit 1 alone identifies the granted client.
  assign w_gidx     = r_grant[1];
  assign w_ready    = dout_ready[w_gidx];
  assign w_abort    = abort[w_gidx];
  assign w_len_sel  = w_gidx ? len1 : len0;
  assign w_can_load = !r_valid || w_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_last      <= CLIENT_FDC;
      r_remaining <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_last      <= w_last_nxt;
      r_remaining <= w_remaining_nxt;
      r_dout      <= w_dout_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_last_nxt      = r_last;
    w_remaining_nxt = r_remaining;
    w_dout_nxt      = r_dout;
    w_valid_nxt     = r_valid;
    w_pop           = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_grant_nxt = client_onehot(rr_pick(req, r_last));
          w_state_nxt = GRANT;
        end
      end

      GRANT: begin
        w_remaining_nxt = w_len_sel;
        w_state_nxt     = (w_len_sel == '0) ? DONE : XFER;
      end

      XFER: begin
        if (w_abort) begin
          // Held byte is dropped; unread bytes stay in the FIFO.
          w_valid_nxt = 1'b0;
          w_state_nxt = DONE;
        end else begin
          w_pop = (r_remaining != '0) && fifo_data_available && w_can_load;
          if (w_pop) begin
            w_dout_nxt      = fifo_out;
            w_valid_nxt     = 1'b1;
            w_remaining_nxt = r_remaining - LEN_ONE;
          end else if (r_valid && w_ready) begin
            w_valid_nxt = 1'b0;
          end
          if ((r_remaining == '0) && w_can_load) begin
            w_state_nxt = DONE;
          end
        end
      end

      DONE: begin
        w_last_nxt  = w_gidx;
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign fifo_rd    = w_pop;
  assign dout       = r_dout;
  assign dout_valid = r_valid ? r_grant : 2'b00;
  assign grant      = r_grant;
  assign done       = (r_state == DONE) ? r_grant : 2'b00;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_io_fifo_arbiter.sv
// Bench for io_fifo_arbiter: a queue-based FIFO, a transaction-level model
// checked every cycle, and directed scenarios with hand-computed timelines.
module tb_io_fifo_arbiter;

  localparam int DW = 8;
  localparam int LW = 10;

  logic          clk;
  logic          reset_n;
  logic [1:0]    req;
  logic [LW-1:0] len0;
  logic [LW-1:0] len1;
  logic [1:0]    abort;
  logic          fifo_data_available;
  logic [DW-1:0] fifo_out;
  logic          fifo_rd;
  logic [DW-1:0] dout;
  logic [1:0]    dout_valid;
  logic [1:0]    dout_ready;
  logic [1:0]    grant;
  logic [1:0]    done;
  logic          busy;

  io_fifo_arbiter #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req                 (req),
    .len0                (len0),
    .len1                (len1),
    .abort               (abort),
    .fifo_data_available (fifo_data_available),
    .fifo_out            (fifo_out),
    .fifo_rd             (fifo_rd),
    .dout                (dout),
    .dout_valid          (dout_valid),
    .dout_ready          (dout_ready),
    .grant               (grant),
    .done                (done),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  logic       m_last;
  logic       m_active;
  logic       m_win;
  logic       m_abort;
  int         m_len;
  int         m_pops;
  logic [1:0] m_prev_grant;
  logic [1:0] m_prev_req;
  logic [1:0] m_prev_done;

  int          lg_i;
  logic [31:0] v_rd;
  logic [31:0] v_done0;
  logic [31:0] v_done1;
  logic [31:0] v_valid;
  logic [31:0] v_busy;
  logic [1:0]  lg_grant[32];
  logic [7:0]  lg_dout[32];
  logic [1:0]  lg_valid[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  task automatic refresh();
    fifo_data_available = (fq.size() != 0);
    fifo_out = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  task automatic flush_fifo();
    fq.delete();
    refresh();
  endtask

  // Transaction-level model: who must win, how many bytes, in what order.
  task automatic model_check();
    logic rising;
    logic exp_w;
    logic ok;
    if (!reset_n) begin
      chk("reset_outputs", {15'd0, fifo_rd, dout, dout_valid, grant, done, busy}, 32'd0);
      m_last = 1'b1;
      m_active = 1'b0;
      exp_q.delete();
      m_prev_grant = 2'b00;
      m_prev_done = 2'b00;
      m_prev_req = req;
      return;
    end
    chk("grant_onehot", {31'd0, ($countones(grant) <= 1)}, 32'd1);
    chk("busy_vs_grant", {31'd0, busy}, {31'd0, (grant != 2'b00)});
    chk("valid_outside_grant", {30'd0, dout_valid & ~grant}, 32'd0);
    chk("done_outside_grant", {30'd0, done & ~grant}, 32'd0);

    rising = (m_prev_grant == 2'b00) && (grant != 2'b00);
    exp_w = (m_prev_req == 2'b11) ? ~m_last : m_prev_req[1];
    if (rising) begin
      chk("grant_winner", {30'd0, grant}, (m_prev_req == 2'b00) ? 32'd0 : {30'd0, oh(exp_w)});
      chk("grant_gap_after_done", {30'd0, m_prev_done}, 32'd0);
      m_active = 1'b1;
      m_win = exp_w;
      m_len = exp_w ? int'(len1) : int'(len0);
      m_pops = 0;
      m_abort = 1'b0;
    end else if (m_active) begin
      chk("grant_hold", {30'd0, grant}, {30'd0, oh(m_win)});
    end else begin
      chk("grant_idle", {30'd0, grant}, 32'd0);
    end

    if (m_active && dout_valid[m_win]) begin
      chk("valid_has_popped_byte", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        chk("dout_data", {24'd0, dout}, {24'd0, exp_q[0]});
        if (dout_ready[m_win]) void'(exp_q.pop_front());
      end
    end

    if (fifo_rd) begin
      ok = m_active && !rising && fifo_data_available && (m_pops < m_len) &&
           !abort[m_win] && !(dout_valid[m_win] && !dout_ready[m_win]);
      chk("rd_allowed", {31'd0, ok}, 32'd1);
      exp_q.push_back(fifo_out);
      m_pops++;
    end

    if (m_active && !rising && abort[m_win] && (done == 2'b00)) m_abort = 1'b1;

    if (done != 2'b00) begin
      chk("done_owner", {29'd0, m_active, done}, {29'd0, 1'b1, oh(m_win)});
      if (!m_abort) begin
        chk("done_byte_count", m_pops, m_len);
        chk("done_all_delivered", exp_q.size(), 32'd0);
      end
      m_last = m_win;
      m_active = 1'b0;
      exp_q.delete();
    end

    m_prev_grant = grant;
    m_prev_req = req;
    m_prev_done = done;
  endtask

  task automatic begin_log();
    lg_i = 0;
    v_rd = '0;
    v_done0 = '0;
    v_done1 = '0;
    v_valid = '0;
    v_busy = '0;
  endtask

  // One clock: sample and check at the falling edge, advance the FIFO after
  // the rising edge; the caller changes inputs once this returns.
  task automatic step();
    logic rd_s;
    @(negedge clk);
    model_check();
    rd_s = fifo_rd;
    if (lg_i < 32) begin
      v_rd[lg_i] = fifo_rd;
      v_done0[lg_i] = done[0];
      v_done1[lg_i] = done[1];
      v_valid[lg_i] = |dout_valid;
      v_busy[lg_i] = busy;
      lg_grant[lg_i] = grant;
      lg_dout[lg_i] = dout;
      lg_valid[lg_i] = dout_valid;
      lg_i++;
    end
    @(posedge clk);
    #1;
    if (rd_s && (fq.size() != 0)) void'(fq.pop_front());
    refresh();
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    reset_n = 1'b0;
    req = 2'b00;
    len0 = '0;
    len1 = '0;
    abort = 2'b00;
    dout_ready = 2'b00;
    m_last = 1'b1;
    m_active = 1'b0;
    m_win = 1'b0;
    m_abort = 1'b0;
    m_len = 0;
    m_pops = 0;
    m_prev_grant = 2'b00;
    m_prev_req = 2'b00;
    m_prev_done = 2'b00;
    begin_log();
    flush_fifo();
    @(posedge clk);
    #1;
    step();
    reset_n = 1'b1;
    step();
    chk("post_reset_grant", {30'd0, grant}, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    // Single transfer, client 0, four bytes.
    for (int i = 0; i < 4; i++) push(8'(32'hA0 + i));
    len0 = 10'd4;
    dout_ready = 2'b01;
    req = 2'b01;
    begin_log();
    step();
    req = 2'b00;
    repeat (9) step();
    chk("single_rd_cycles", v_rd, 32'h0000_003C);
    chk("single_valid_cycles", v_valid, 32'h0000_0078);
    chk("single_done0", v_done0, 32'h0000_0080);
    chk("single_done1", v_done1, 32'h0);
    chk("single_dout_seq", {lg_dout[3], lg_dout[4], lg_dout[5], lg_dout[6]}, 32'hA0A1A2A3);
    chk("single_grant", {30'd0, lg_grant[1]}, 32'd1);
    chk("single_fifo_empty", fq.size(), 32'd0);

    // Tie after reset: client 0, then client 1, then client 0 again.
    do_reset();
    for (int i = 0; i < 6; i++) push(8'(32'hB0 + i));
    len0 = 10'd2;
    len1 = 10'd2;
    dout_ready = 2'b11;
    req = 2'b11;
    begin_log();
    repeat (14) step();
    req = 2'b00;
    repeat (6) step();
    chk("tie_first_grant", {30'd0, lg_grant[1]}, 32'd1);
    chk("tie_second_grant", {30'd0, lg_grant[7]}, 32'd2);
    chk("tie_third_grant", {30'd0, lg_grant[13]}, 32'd1);
    chk("tie_done0", v_done0, 32'h0002_0020);
    chk("tie_done1", v_done1, 32'h0000_0800);
    chk("tie_rd_cycles", v_rd, 32'h0000_C30C);
    chk("tie_fifo_empty", fq.size(), 32'd0);

    // Backpressure: ready 1,0,0,1,1 once bytes start arriving.
    for (int i = 0; i < 3; i++) push(8'(32'hC0 + i));
    len0 = 10'd3;
    dout_ready = 2'b01;
    req = 2'b01;
    begin_log();
    step();
    req = 2'b00;
    repeat (2) step();
    begin
      logic [4:0] pat;
      pat = 5'b11001;
      for (int i = 0; i < 5; i++) begin
        dout_ready = {1'b0, pat[i]};
        step();
      end
    end
    dout_ready = 2'b01;
    repeat (3) step();
    chk("bp_rd_cycles", v_rd, 32'h0000_004C);
    chk("bp_dout_held", {16'd0, lg_dout[4], lg_dout[5]}, 32'h0000_C1C1);
    chk("bp_valid_cycles", v_valid, 32'h0000_00F8);
    chk("bp_done0", v_done0, 32'h0000_0100);

    // Underrun: client 1 wants 4 bytes, only 2 present until later.
    push(8'hD0);
    push(8'hD1);
    len1 = 10'd4;
    dout_ready = 2'b10;
    req = 2'b10;
    begin_log();
    step();
    req = 2'b00;
    repeat (13) step();
    chk("underrun_stall_grant", {30'd0, lg_grant[9]}, 32'd2);
    chk("underrun_stall_busy", v_busy[9], 32'd1);
    chk("underrun_rd_before_push", v_rd, 32'h0000_000C);
    push(8'hD2);
    push(8'hD3);
    repeat (6) step();
    chk("underrun_rd_cycles", v_rd, 32'h0000_C00C);
    chk("underrun_done1", v_done1, 32'h0002_0000);

    // Abort of client 1 after three pops; a stray abort[0] is ignored.
    for (int i = 0; i < 8; i++) push(8'(32'hF0 + i));
    len1 = 10'd8;
    dout_ready = 2'b10;
    req = 2'b10;
    begin_log();
    step();
    req = 2'b00;
    repeat (2) step();
    abort = 2'b01;
    step();
    abort = 2'b00;
    step();
    abort = 2'b10;
    step();
    abort = 2'b00;
    repeat (4) step();
    chk("abort_rd_cycles", v_rd, 32'h0000_001C);
    chk("abort_done1", v_done1, 32'h0000_0040);
    chk("abort_valid_before", {30'd0, lg_valid[5]}, 32'd2);
    chk("abort_valid_after", {30'd0, lg_valid[6]}, 32'd0);
    chk("abort_fifo_left", fq.size(), 32'd5);
    chk("abort_fifo_head", {24'd0, fq[0]}, 32'h0000_00F3);
    flush_fifo();

    // Zero length on client 0: done two cycles after req is taken, no pops.
    push(8'hE0);
    len0 = 10'd0;
    dout_ready = 2'b01;
    req = 2'b01;
    begin_log();
    step();
    req = 2'b00;
    repeat (5) step();
    chk("zero_rd_none", v_rd, 32'h0);
    chk("zero_done0", v_done0, 32'h0000_0004);
    chk("zero_grant", {30'd0, lg_grant[1]}, 32'd1);
    chk("zero_fifo_untouched", fq.size(), 32'd1);
    flush_fifo();

    // Reset mid-transfer: last served was client 0, so only a reset of the
    // round-robin pointer makes client 0 win the following tie.
    for (int i = 0; i < 4; i++) push(8'(32'h60 + i));
    len0 = 10'd4;
    dout_ready = 2'b01;
    req = 2'b01;
    begin_log();
    step();
    req = 2'b00;
    repeat (3) step();
    chk("midreset_was_busy", v_busy[3], 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_async_outputs", {15'd0, fifo_rd, dout, dout_valid, grant, done, busy}, 32'd0);
    step();
    reset_n = 1'b1;
    begin_log();
    repeat (4) step();
    chk("midreset_no_done", v_done0 | v_done1, 32'h0);
    chk("midreset_no_rd", v_rd, 32'h0);
    flush_fifo();
    for (int i = 0; i < 4; i++) push(8'(32'h70 + i));
    len0 = 10'd2;
    len1 = 10'd2;
    dout_ready = 2'b11;
    req = 2'b11;
    begin_log();
    step();
    req = 2'b00;
    repeat (7) step();
    chk("midreset_tie_grant", {30'd0, lg_grant[1]}, 32'd1);
    chk("midreset_tie_done0", v_done0, 32'h0000_0020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
